// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bus bundle around the instruction fetch unit: the PC handshake from the
//   PC stage, the instruction-memory read port and the decoder-side FIFO head.
//   slave  : the fetch unit's view (consumes PCs, drives memory + decoder).
//   master : the surrounding datapath / testbench view.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6
);
  // PC stage -> fetch
  logic [63:0]       pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  // fetch <-> instruction memory
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  // fetch -> decoder
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_out;
  logic [63:0]       instr_pc;
  logic              instr_fault;

  modport slave (
    input  pc_in, pc_valid, flush, mem_req_ready, mem_rvalid, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );

  modport master (
    output pc_in, pc_valid, flush, mem_req_ready, mem_rvalid, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Accepts PCs (instruction indices), issues one word read at a time to
//   instruction memory and queues {pc, instruction, fault} for decode in a
//   DEPTH-entry FIFO. A flush (taken branch) empties the FIFO and discards any
//   in-flight read; a read already accepted by memory is drained silently.
//   PCs beyond the memory range never touch memory and are queued as faults.
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   io_bus   : instr_fetch_unit_if.slave (PC handshake, memory port, FIFO head)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  instr_fetch_unit_if.slave    io_bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [63:0]             r_pc;
  logic                    r_oor_pend;   // out-of-range entry waiting to be pushed

  logic [DEPTH-1:0][31:0]  r_q_instr;
  logic [DEPTH-1:0][63:0]  r_q_pc;
  logic [DEPTH-1:0]        r_q_flt;
  logic [PW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_count;

  logic                    w_in_range, w_room, w_pc_ready, w_accept;
  logic                    w_push_mem, w_push_oor, w_push, w_pop;
  logic [CW:0]             w_fill;

  // Full 64-bit compare: any set bit above ADDR_W is out of range.
  assign w_in_range = (io_bus.pc_in >> ADDR_W) == 64'd0;
  // A pending out-of-range push already owns a slot.
  assign w_fill     = {1'b0, r_count} + {{CW{1'b0}}, r_oor_pend};
  assign w_room     = w_fill < DEPTH_C;
  // Gated by reset so the PC stage sees no acceptance while held in reset.
  assign w_pc_ready = i_rst_n & (r_state == S_IDLE) & w_room & ~io_bus.flush;
  assign w_accept   = io_bus.pc_valid & w_pc_ready;

  assign w_push_mem = (r_state == S_WAIT) & io_bus.mem_rvalid & ~io_bus.flush;
  assign w_push_oor = r_oor_pend & ~io_bus.flush;
  assign w_push     = w_push_mem | w_push_oor;
  assign w_pop      = io_bus.instr_ready & (r_count != '0) & ~io_bus.flush;

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- FSM: next state (flush overrides normal progress) ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_in_range) w_state_nxt = S_REQ;
      S_REQ: begin
        if (io_bus.flush)              w_state_nxt = io_bus.mem_req_ready ? S_DRAIN : S_IDLE;
        else if (io_bus.mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.mem_rvalid)         w_state_nxt = S_IDLE;
        else if (io_bus.flush)         w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (io_bus.mem_rvalid)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    io_bus.pc_ready    = w_pc_ready;
    io_bus.mem_req     = (r_state == S_REQ);
    io_bus.mem_addr    = r_pc[ADDR_W-1:0];
    io_bus.instr_valid = (r_count != '0);
    io_bus.instr_out   = '0;
    io_bus.instr_pc    = '0;
    io_bus.instr_fault = 1'b0;
    if (r_count != '0) begin
      io_bus.instr_out   = r_q_instr[r_rptr];
      io_bus.instr_pc    = r_q_pc[r_rptr];
      io_bus.instr_fault = r_q_flt[r_rptr];
    end
  end

  // ---- latched PC and deferred out-of-range push ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= '0;
      r_oor_pend <= 1'b0;
    end else begin
      if (w_accept) r_pc <= io_bus.pc_in;
      r_oor_pend <= w_accept & ~w_in_range;
    end
  end

  // ---- FIFO ----
  // The pending out-of-range cycle is always spent in IDLE, so the two push
  // sources never coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_instr <= '0;
      r_q_pc    <= '0;
      r_q_flt   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else if (io_bus.flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_wptr] <= w_push_oor ? 32'h0 : io_bus.mem_rdata;
        r_q_pc[r_wptr]    <= r_pc;
        r_q_flt[r_wptr]   <= w_push_oor;
        r_wptr            <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed vector table for the documented scenarios, a hand-written
//   asynchronous-reset sequence, then randomized traffic against a
//   transaction-level reference model (queue of expected decoder entries).
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        pcv;
    logic [63:0] pc;
    logic        fl, mrr, rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_pr, e_mreq;
    logic [ADDR_W-1:0] e_addr;
    logic        e_iv;
    logic [31:0] e_out;
    logic [63:0] e_pc;
    logic        e_flt;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic        flt;
  } ent_t;

  vec_t vecs[$];

  function automatic void v(input int pcv, input longint pc, input int fl, input int mrr,
                            input int rv, input int rd, input int ir,
                            input int e_pr, input int e_mreq, input int e_addr, input int e_iv,
                            input int e_out, input longint e_pc, input int e_flt);
    vec_t t;
    t.pcv = (pcv != 0); t.pc = 64'(pc); t.fl = (fl != 0); t.mrr = (mrr != 0);
    t.rv = (rv != 0); t.rd = 32'(rd); t.ir = (ir != 0);
    t.e_pr = (e_pr != 0); t.e_mreq = (e_mreq != 0); t.e_addr = ADDR_W'(e_addr);
    t.e_iv = (e_iv != 0); t.e_out = 32'(e_out); t.e_pc = 64'(e_pc); t.e_flt = (e_flt != 0);
    vecs.push_back(t);
  endfunction

  function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
    return 32'hF840_0000 ^ (32'(a) * 32'h0101_0107);
  endfunction

  task automatic drive(input logic pcv, input logic [63:0] pc, input logic fl, input logic mrr,
                       input logic rv, input logic [31:0] rd, input logic ir);
    bus.pc_valid = pcv; bus.pc_in = pc; bus.flush = fl; bus.mem_req_ready = mrr;
    bus.mem_rvalid = rv; bus.mem_rdata = rd; bus.instr_ready = ir;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input logic e_pr, input logic e_mreq,
                         input logic [ADDR_W-1:0] e_addr, input logic e_iv,
                         input logic [31:0] e_out, input logic [63:0] e_pc, input logic e_flt);
    check({nm, " pc_ready"},    64'(bus.pc_ready),    64'(e_pr));
    check({nm, " mem_req"},     64'(bus.mem_req),     64'(e_mreq));
    check({nm, " instr_valid"}, 64'(bus.instr_valid), 64'(e_iv));
    if (e_mreq) check({nm, " mem_addr"}, 64'(bus.mem_addr), 64'(e_addr));
    if (e_iv) begin
      check({nm, " instr_out"},   64'(bus.instr_out),   64'(e_out));
      check({nm, " instr_pc"},    bus.instr_pc,         e_pc);
      check({nm, " instr_fault"}, 64'(bus.instr_fault), 64'(e_flt));
    end
  endtask

  task automatic cyc(input logic pcv, input logic [63:0] pc, input logic fl, input logic mrr,
                     input logic rv, input logic [31:0] rd, input logic ir);
    @(posedge clk); #1;
    drive(pcv, pc, fl, mrr, rv, rd, ir);
    @(negedge clk);
  endtask

  // reference model state
  int          ph;       // 0 no fetch, 1 waiting for memory accept, 2 waiting for data
  bit          drain;
  logic [63:0] mpc;
  bit          pend;
  logic [63:0] pend_pc;
  ent_t        q[$];
  int          mdel;
  logic [ADDR_W-1:0] maddr;

  initial begin
    logic pcv, fl, mrr, rv, ir, e_pr, e_iv;
    logic [63:0] pc;
    logic [31:0] rd;
    int had;

    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- reset values ----
    #12;
    check("rst mem_req",     64'(bus.mem_req),     0);
    check("rst mem_addr",    64'(bus.mem_addr),    0);
    check("rst instr_valid", 64'(bus.instr_valid), 0);
    check("rst instr_out",   64'(bus.instr_out),   0);
    check("rst instr_pc",    bus.instr_pc,         0);
    check("rst instr_fault", 64'(bus.instr_fault), 0);
    check("rst pc_ready",    64'(bus.pc_ready),    0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("post-rst pc_ready", 64'(bus.pc_ready), 1);

    // ---- directed table ----
    //  pcv pc  fl mrr rv rd  ir | pr mreq addr iv out pc flt
    // basic fetch, pc=5
    v(1, 5, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1,  0, 1, 5, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 32'hF8400020, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 32'hF8400020, 5, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // backpressure: fill with pcs 0,1, then pop in order
    v(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 32'hA0, 0,  0, 0, 0, 0, 0, 0, 0);
    v(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 32'hA0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 32'hA0, 0, 0);
    v(0, 0, 0, 0, 1, 32'hA1, 0,  0, 0, 0, 1, 32'hA0, 0, 0);
    v(1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'hA0, 0, 0);
    v(1, 2, 0, 0, 0, 0, 1,  0, 0, 0, 1, 32'hA0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 32'hA1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 32'hA1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // flush in WAIT -> DRAIN, late data dropped, then pc=20
    v(1, 7, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1,  0, 1, 7, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 32'hDEAD, 1,  0, 0, 0, 0, 0, 0, 0);
    v(1, 20, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1,  0, 1, 20, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 32'h1234, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 32'h1234, 20, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // out of range pc=64: no memory access, fault entry
    v(1, 64, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 64, 1);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // huge pc with small low bits is still out of range
    v(1, 64'h8000_0000_0000_0003, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 64'h8000_0000_0000_0003, 1);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // flush suppresses a pending out-of-range push
    v(1, 65, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // flush empties a non-empty FIFO
    v(1, 100, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 100, 1);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // memory stall 4 cycles, then flush during the stall
    v(1, 9, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 1, 9, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 1, 9, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 1, 9, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 1, 9, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1,  0, 1, 9, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // flush in REQ while memory accepts -> DRAIN
    v(1, 3, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 1, 0, 0, 1,  0, 1, 3, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 32'hBAD, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    // flush in WAIT together with rvalid -> IDLE, data dropped
    v(1, 4, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1,  0, 1, 4, 0, 0, 0, 0);
    v(0, 0, 1, 0, 1, 32'hBEEF, 1,  0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].pcv, vecs[i].pc, vecs[i].fl, vecs[i].mrr, vecs[i].rv, vecs[i].rd, vecs[i].ir);
      chk_out($sformatf("row%0d", i), vecs[i].e_pr, vecs[i].e_mreq, vecs[i].e_addr,
              vecs[i].e_iv, vecs[i].e_out, vecs[i].e_pc, vecs[i].e_flt);
    end

    // ---- asynchronous reset mid-fetch with a queued entry ----
    cyc(1, 70, 0, 0, 0, 0, 0);
    check("arst setup pc_ready", 64'(bus.pc_ready), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    check("arst setup iv", 64'(bus.instr_valid), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("arst setup mem_req", 64'(bus.mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst mem_req",     64'(bus.mem_req),     0);
    check("arst instr_valid", 64'(bus.instr_valid), 0);
    check("arst pc_ready",    64'(bus.pc_ready),    0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h55, 1);
    @(negedge clk);
    check("arst release pc_ready", 64'(bus.pc_ready), 1);
    check("arst stray rvalid mem_req", 64'(bus.mem_req), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("arst stray rvalid iv", 64'(bus.instr_valid), 0);

    // ---- randomized traffic vs reference model ----
    ph = 0; drain = 0; mpc = 0; pend = 0; pend_pc = 0; mdel = 0; maddr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      pcv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) pc = 64'($urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 1) pc = 64'(64 + $urandom_range(0, 200));
      else pc = {$urandom, $urandom} | 64'h0000_0100_0000_0000;
      fl  = ($urandom_range(0, 15) == 0);
      mrr = 1'($urandom_range(0, 1));
      ir  = ($urandom_range(0, 9) < 6);
      rv  = (mdel == 1);
      if (mdel > 0) mdel--;
      rd  = rv ? memword(maddr) : $urandom;
      drive(pcv, pc, fl, mrr, rv, rd, ir);
      @(negedge clk);

      e_pr = (ph == 0) && ((q.size() + int'(pend)) < DEPTH) && !fl;
      e_iv = (q.size() > 0);
      if (e_iv) chk_out($sformatf("rnd%0d", c), e_pr, ph == 1, mpc[ADDR_W-1:0], 1'b1,
                        q[0].ins, q[0].pc, q[0].flt);
      else      chk_out($sformatf("rnd%0d", c), e_pr, ph == 1, mpc[ADDR_W-1:0], 1'b0,
                        32'h0, 64'h0, 1'b0);

      // memory side: latch address and schedule one response per accepted request
      if (bus.mem_req && mrr) begin
        maddr = bus.mem_addr;
        mdel  = $urandom_range(1, 3);
      end

      // model advance across the coming edge
      had = q.size();
      if (fl) begin
        q.delete();
        pend = 0;
        if (ph == 1) begin
          if (mrr) begin ph = 2; drain = 1; end
          else ph = 0;
        end else if (ph == 2) begin
          if (rv) begin ph = 0; drain = 0; end
          else drain = 1;
        end
      end else begin
        if (ir && had > 0) void'(q.pop_front());
        if (pend) begin
          q.push_back('{ins: 32'h0, pc: pend_pc, flt: 1'b1});
          pend = 0;
        end
        if (ph == 2 && rv) begin
          if (!drain) q.push_back('{ins: memword(mpc[ADDR_W-1:0]), pc: mpc, flt: 1'b0});
          ph = 0; drain = 0;
        end else if (ph == 1 && mrr) ph = 2;
        if (pcv && e_pr) begin
          if (pc < 64'(2**ADDR_W)) begin ph = 1; mpc = pc; end
          else begin pend = 1; pend_pc = pc; end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
